// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fsm_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 32'h0;
  localparam logic [PC_W-1:0]    PC_STEP    = 64'd4;

  // Instructions are 4-byte words; any low address bit set is a bad target.
  function automatic logic is_aligned(input logic [PC_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Control, memory-load and fetch-result signals of the fetch stage.
interface inst_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int IMEM_DEPTH = 64
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic               stall;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               imem_we;
  logic [AW-1:0]      imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc_out;
  logic               instr_valid;
  logic               halted;
  logic               misalign_err;
  logic [31:0]        fetch_count;

  // Driver side: the pipeline control and memory loader.
  modport master (
    output stall, redirect_valid, redirect_pc, imem_we, imem_waddr, imem_wdata,
    input  instr, pc_out, instr_valid, halted, misalign_err, fetch_count
  );

  // Fetch unit side.
  modport slave (
    input  stall, redirect_valid, redirect_pc, imem_we, imem_waddr, imem_wdata,
    output instr, pc_out, instr_valid, halted, misalign_err, fetch_count
  );

endinterface

// File: rtl/inst_fetch_unit_imem_rom.sv
// Word-addressed 1R1W instruction store: combinational read, synchronous write.
// A same-cycle read and write of one word returns the old contents.
module imem_rom #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Loader write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, instruction store and run/halt FSM.
// Optional macro FETCH_COUNT_EN builds a 32-bit counter of valid fetches;
// without it fetch_count is tied to zero.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              IMEM_DEPTH = 64,
  parameter logic [PC_W-1:0] RESET_PC   = 64'h0
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_unit_if.slave   bus
);

  localparam int              AW       = $clog2(IMEM_DEPTH);
  localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(IMEM_DEPTH * 4);

  fsm_state_e         state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_out_q;
  logic               instr_valid_q;
  logic               halted_q;
  logic               misalign_err_q;

  logic [INSTR_W-1:0] fetch_word;
  logic               out_of_range;
  logic               fetch_fire;

  imem_rom #(
    .DEPTH (IMEM_DEPTH),
    .WIDTH (INSTR_W),
    .AW    (AW)
  ) u_imem (
    .clk     (clk),
    .we_i    (bus.imem_we),
    .waddr_i (bus.imem_waddr),
    .wdata_i (bus.imem_wdata),
    .raddr_i (pc_q[AW+1:2]),
    .rdata_o (fetch_word)
  );

  // A real fetch happens only in RUN with no redirect, no stall, the PC
  // inside the store and a non-zero word; anything else unstalled halts.
  assign out_of_range = (pc_q >= PC_LIMIT);
  assign fetch_fire   = (state_q == S_RUN) && !bus.redirect_valid && !bus.stall &&
                        !out_of_range && (fetch_word != HALT_INSTR);

  // Run/halt FSM with PC and all fetch outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      instr_q        <= '0;
      pc_out_q       <= '0;
      instr_valid_q  <= 1'b0;
      halted_q       <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          instr_valid_q <= 1'b0;
          state_q       <= S_RUN;
        end
        S_RUN: begin
          if (bus.redirect_valid) begin
            instr_valid_q <= 1'b0;
            if (is_aligned(bus.redirect_pc)) begin
              pc_q <= bus.redirect_pc;
            end else begin
              misalign_err_q <= 1'b1;
              halted_q       <= 1'b1;
              state_q        <= S_HALT;
            end
          end else if (!bus.stall) begin
            if (fetch_fire) begin
              instr_q       <= fetch_word;
              pc_out_q      <= pc_q;
              instr_valid_q <= 1'b1;
              pc_q          <= pc_q + PC_STEP;
            end else begin
              instr_valid_q <= 1'b0;
              halted_q      <= 1'b1;
              state_q       <= S_HALT;
            end
          end
        end
        S_HALT: begin
          instr_valid_q <= 1'b0;
          if (bus.redirect_valid) begin
            if (is_aligned(bus.redirect_pc)) begin
              pc_q     <= bus.redirect_pc;
              halted_q <= 1'b0;
              state_q  <= S_RUN;
            end else begin
              misalign_err_q <= 1'b1;
            end
          end
        end
        default: begin
          instr_valid_q <= 1'b0;
          halted_q      <= 1'b0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_q;

  // Counts every cycle a valid instruction is loaded; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_count_q <= '0;
    else if (fetch_fire) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign bus.fetch_count = fetch_count_q;
`else
  assign bus.fetch_count = 32'h0;
`endif

  assign bus.instr        = instr_q;
  assign bus.pc_out       = pc_out_q;
  assign bus.instr_valid  = instr_valid_q;
  assign bus.halted       = halted_q;
  assign bus.misalign_err = misalign_err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: each driven cycle pushes its
// expected outputs, which are popped and compared after the clock edge.
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [63:0] pc;
    logic        h;
    logic        m;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  inst_fetch_unit_if #(.IMEM_DEPTH(DEPTH)) bus();

  inst_fetch_unit #(
    .IMEM_DEPTH (DEPTH),
    .RESET_PC   (64'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cnt_model = 0;
  exp_t        exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the cycle being driven, clock it, then score.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [63:0] pc, input logic h, input logic m,
                      input logic fire);
    exp_t e;
    exp_t got;
    if (fire) cnt_model++;
    e.v = v; e.ins = ins; e.pc = pc; e.h = h; e.m = m;
`ifdef FETCH_COUNT_EN
    e.cnt = cnt_model;
`else
    e.cnt = 32'h0;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk({tag, ".valid"},    64'(bus.instr_valid),  64'(got.v));
    chk({tag, ".halted"},   64'(bus.halted),       64'(got.h));
    chk({tag, ".misalign"}, 64'(bus.misalign_err), 64'(got.m));
    chk({tag, ".count"},    64'(bus.fetch_count),  64'(got.cnt));
    if (got.v) begin
      chk({tag, ".instr"}, 64'(bus.instr), 64'(got.ins));
      chk({tag, ".pc"},    bus.pc_out,     got.pc);
    end
  endtask

  task automatic reset_check(input string tag);
    chk({tag, ".instr"},    64'(bus.instr),        64'h0);
    chk({tag, ".pc"},       bus.pc_out,            64'h0);
    chk({tag, ".valid"},    64'(bus.instr_valid),  64'h0);
    chk({tag, ".halted"},   64'(bus.halted),       64'h0);
    chk({tag, ".misalign"}, 64'(bus.misalign_err), 64'h0);
    chk({tag, ".count"},    64'(bus.fetch_count),  64'h0);
  endtask

  task automatic imem_write(input logic [AW-1:0] a, input logic [31:0] d);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = a;
    bus.imem_wdata = d;
    @(posedge clk);
    #1;
    bus.imem_we = 1'b0;
  endtask

  // Assert reset between edges, check it took effect at once, then release.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    reset_check(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt_model = 0;
  endtask

  task automatic redirect(input logic [63:0] a);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.imem_we        = 1'b0;
    bus.imem_waddr     = '0;
    bus.imem_wdata     = 32'h0;

    #1 rst = 1'b1;
    imem_write(AW'(0), 32'h006283B3);
    imem_write(AW'(1), 32'h40538433);
    imem_write(AW'(2), 32'h005474B3);
    imem_write(AW'(3), 32'h00000000);
    reset_check("rst0");
    rst = 1'b0;

    // Straight-line run to the halt marker.
    step("s1.idle", 0, 32'h0,        64'h0, 0, 0, 0);
    step("s1.f0",   1, 32'h006283B3, 64'h0, 0, 0, 1);
    step("s1.f1",   1, 32'h40538433, 64'h4, 0, 0, 1);
    step("s1.f2",   1, 32'h005474B3, 64'h8, 0, 0, 1);
    step("s1.halt", 0, 32'h0,        64'h0, 1, 0, 0);

    // Stall holds, then redirect-under-stall gives one bubble.
    do_reset("rst1");
    step("s2.idle", 0, 32'h0,        64'h0, 0, 0, 0);
    step("s2.f0",   1, 32'h006283B3, 64'h0, 0, 0, 1);
    bus.stall = 1'b1;
    step("s2.st0",  1, 32'h006283B3, 64'h0, 0, 0, 0);
    step("s2.st1",  1, 32'h006283B3, 64'h0, 0, 0, 0);
    bus.stall = 1'b0;
    step("s2.f1",   1, 32'h40538433, 64'h4, 0, 0, 1);
    step("s2.f2",   1, 32'h005474B3, 64'h8, 0, 0, 1);
    bus.stall = 1'b1;
    redirect(64'h8);
    step("s2.bub",  0, 32'h0,        64'h0, 0, 0, 0);
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    step("s2.rd8",  1, 32'h005474B3, 64'h8, 0, 0, 1);
    step("s2.halt", 0, 32'h0,        64'h0, 1, 0, 0);

    // Leave halt, then misaligned redirect halts with a sticky flag.
    redirect(64'h0);
    step("s3.wake", 0, 32'h0,        64'h0, 0, 0, 0);
    bus.redirect_valid = 1'b0;
    step("s3.f0",   1, 32'h006283B3, 64'h0, 0, 0, 1);
    redirect(64'h6);
    step("s3.mis",  0, 32'h0,        64'h0, 1, 1, 0);
    redirect(64'h0);
    step("s3.back", 0, 32'h0,        64'h0, 0, 1, 0);
    bus.redirect_valid = 1'b0;
    step("s3.f0b",  1, 32'h006283B3, 64'h0, 0, 1, 1);

    // Redirect past the end of the store halts without a fetch.
    redirect(64'(DEPTH * 4));
    step("s4.rd",   0, 32'h0,        64'h0, 0, 1, 0);
    bus.redirect_valid = 1'b0;
    bus.stall = 1'b1;
    step("s4.stl",  0, 32'h0,        64'h0, 0, 1, 0);
    bus.stall = 1'b0;
    step("s4.halt", 0, 32'h0,        64'h0, 1, 1, 0);
    bus.stall = 1'b1;
    step("s4.hold", 0, 32'h0,        64'h0, 1, 1, 0);
    bus.stall = 1'b0;

    // Same-cycle write and fetch of one word returns the old word.
    do_reset("rst2");
    step("s5.idle", 0, 32'h0,        64'h0, 0, 0, 0);
    step("s5.f0",   1, 32'h006283B3, 64'h0, 0, 0, 1);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = AW'(1);
    bus.imem_wdata = 32'h00A00093;
    step("s5.rbw",  1, 32'h40538433, 64'h4, 0, 0, 1);
    bus.imem_we = 1'b0;
    redirect(64'h4);
    step("s5.bub",  0, 32'h0,        64'h0, 0, 0, 0);
    bus.redirect_valid = 1'b0;
    step("s5.new",  1, 32'h00A00093, 64'h4, 0, 0, 1);

    // Asynchronous reset while a valid instruction is on the outputs.
    #3;
    rst = 1'b1;
    #1;
    reset_check("rst3");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the R-type datapath and drives its 32-bit instruction input. It holds the PC, a loadable word-addressed instruction memory, and a small run/halt FSM. It supports stall, redirect (flush with one bubble) and a halt condition.

Parameters:
IMEM_DEPTH, 64, number of 32-bit instruction words; must be a power of two, at least 4.
RESET_PC, 64'h0, PC value loaded on reset; must be 4-byte aligned.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
stall  input  1  hold the current outputs and PC.
redirect_valid  input  1  load the PC from redirect_pc.
redirect_pc  input  64  redirect target byte address.
imem_we  input  1  instruction memory write enable.
imem_waddr  input  log2(IMEM_DEPTH)  word address to write.
imem_wdata  input  32  instruction word to write.
instr  output  32  fetched instruction, to the datapath.
pc_out  output  64  byte address of instr.
instr_valid  output  1  instr/pc_out hold a real instruction.
halted  output  1  FSM is in S_HALT.
misalign_err  output  1  sticky flag: a misaligned redirect occurred.
fetch_count  output  32  count of valid fetches (see Optional Feature).

Behaviour:
- Reset is asynchronous and active-high:
  - pc = RESET_PC; instr = 32'h0; pc_out = 64'h0.
  - instr_valid, halted and misalign_err = 0; fetch_count = 0.
  - State = S_IDLE. imem contents are not cleared.
- FSM states: S_IDLE, S_RUN, S_HALT. All outputs are registered.
- S_IDLE: lasts exactly one cycle after rst deasserts, with instr_valid = 0. Goes to S_RUN unconditionally. redirect_valid is ignored in this state.
- S_RUN, per cycle, in priority order:
  1. redirect_valid = 1:
     - If redirect_pc[1:0] != 0: misalign_err <= 1, go to S_HALT.
     - Otherwise: pc <= redirect_pc.
     - In both cases instr_valid <= 0, producing one bubble. This beats stall.
  2. stall = 1: pc, instr, pc_out and instr_valid all hold.
  3. pc >= 4*IMEM_DEPTH: instr_valid <= 0, go to S_HALT.
  4. Fetched word imem[pc[log2(IMEM_DEPTH)+1:2]] == 32'h0 (halt marker): instr_valid <= 0, go to S_HALT. The PC is not advanced.
  5. Otherwise:
     - instr <= fetched word; pc_out <= pc; instr_valid <= 1; pc <= pc + 4.
     - Latency: one cycle from the PC value to valid instr.
- S_HALT:
  - halted = 1; instr_valid = 0; stall is ignored.
  - An aligned redirect_valid sets pc <= redirect_pc and returns to S_RUN. The first valid instruction appears on the following cycle.
  - A misaligned redirect keeps the FSM in S_HALT.
- PC arithmetic: 64-bit, wraps modulo 2^64. The wrap is only reachable via redirect and is caught by the range check.
- Memory write:
  - Synchronous and accepted in any state, including during stall.
  - A write and a fetch to the same word in the same cycle: the fetch returns the old data (read-before-write).
- Reset mid-operation aborts immediately with no partial outputs.

Optional Feature:
Macro FETCH_COUNT_EN.
- Defined: fetch_count increments by 1 on every cycle that instr_valid is loaded with 1. It wraps at 2^32 and is cleared only by rst.
- Not defined: fetch_count is tied to 32'h0 and no counter register is built.

Decomposition:
- Shared package fetch_pkg holds:
  - fsm state enum (S_IDLE, S_RUN, S_HALT);
  - INSTR_W = 32 and PC_W = 64;
  - HALT_INSTR = 32'h0;
  - PC_STEP = 4.
- One sub-module, imem_rom: a parameterised 1R1W word array with combinational read and synchronous write. The FSM and PC logic stay in the top module.

Test Plan:
- Load imem[0..2] = 32'h006283B3, 32'h40538433, 32'h005474B3 and imem[3] = 0, then release rst. Expected:
  - One idle cycle.
  - Then on three consecutive cycles: instr = 006283B3 / 40538433 / 005474B3 with pc_out = 0 / 4 / 8 and instr_valid = 1.
  - Then halted = 1 and instr_valid = 0.
- Stall: assert stall for 2 cycles after the first valid fetch. instr = 006283B3 and pc_out = 0 are held. Fetch resumes at pc_out = 4 with no instruction skipped.
- Redirect: assert redirect_valid with redirect_pc = 64'h8 while stall = 1. Expected:
  - One bubble (instr_valid = 0).
  - Next cycle instr = 005474B3, pc_out = 8.
- Misaligned redirect: redirect_pc = 64'h6. Expected misalign_err = 1 and halted = 1. A later redirect to 64'h0 resumes with pc_out = 0 while misalign_err stays 1.
- Range: redirect to 4*IMEM_DEPTH (64'h100 for the default IMEM_DEPTH) -> halted = 1 with no valid instruction.
- Async reset asserted mid-stream, between clock edges: all outputs go to their reset values immediately. With FETCH_COUNT_EN, fetch_count = 3 after the first scenario and 0 right after reset.
